// File: rtl/gate2_checker_if.sv
// Bundle of the gate-under-test nets, the run control pulses and the verdict
// outputs. The checker sits on the slave side; the stimulus and the
// result reader sit on the master side.
interface gate2_checker_if #(
  parameter int CNT_W = 16
);
  // Stimulus side: run control plus the gate nets being observed
  logic             START;
  logic             STOP;
  logic             VALID;
  logic             IN1;
  logic             IN2;
  logic             OUT;

  // Verdict side
  logic [CNT_W-1:0] PASS_CNT;
  logic [CNT_W-1:0] ERR_CNT;
  logic [3:0]       COV;
  logic             ERR;
  logic [1:0]       FAIL_IN;
  logic             FAIL_OUT;
  logic             BUSY;
  logic             DONE;
  logic             RESULT_OK;

  modport master (
    output START, STOP, VALID, IN1, IN2, OUT,
    input  PASS_CNT, ERR_CNT, COV, ERR, FAIL_IN, FAIL_OUT, BUSY, DONE, RESULT_OK
  );

  modport slave (
    input  START, STOP, VALID, IN1, IN2, OUT,
    output PASS_CNT, ERR_CNT, COV, ERR, FAIL_IN, FAIL_OUT, BUSY, DONE, RESULT_OK
  );
endinterface

// File: rtl/gate2_checker.sv
// Checker for a 2-input gate under test. Each qualified sample is registered
// once and checked on the following edge against the expected function of
// its inputs; results are counted, coverage of the four input combinations
// is tracked and the first failure is captured for the end-of-run verdict.
module gate2_checker #(
  parameter int CNT_W = 16,
  parameter int FUNC  = 0   // 0 = AND, 1 = OR, 2 = XOR, 3 = NAND
) (
  input  logic          CLK,
  input  logic          RST_N,
  gate2_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;

  // One-deep sample pipeline: {IN2,IN1}, OUT and a valid bit
  logic             smp_v_q, smp_v_d;
  logic [1:0]       smp_in_q, smp_in_d;
  logic             smp_out_q, smp_out_d;

  // Run results
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic             err_q, err_d;
  logic [1:0]       fail_in_q, fail_in_d;
  logic             fail_out_q, fail_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             exp_out;
  logic             match;

  // Expected gate output for the registered sample, and the 4-state compare
  always_comb begin
    case (FUNC)
      0:       exp_out = smp_in_q[1] & smp_in_q[0];
      1:       exp_out = smp_in_q[1] | smp_in_q[0];
      2:       exp_out = smp_in_q[1] ^ smp_in_q[0];
      default: exp_out = ~(smp_in_q[1] & smp_in_q[0]);
    endcase
    // An x or z on the observed OUT must never count as a pass.
    match = (smp_out_q === exp_out);
  end

  // Next-state for the run FSM, sample pipeline and result registers
  always_comb begin
    // NOTE: every _d starts as its held value so no path through this block
    // can leave a variable unassigned and infer a latch.
    state_d    = state_q;
    smp_v_d    = 1'b0;
    smp_in_d   = smp_in_q;
    smp_out_d  = smp_out_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    cov_d      = cov_q;
    err_d      = err_q;
    fail_in_d  = fail_in_q;
    fail_out_d = fail_out_q;

    if (bus.START) begin
      // A (re)start from any state wipes the run, including a pending sample.
      state_d    = ST_RUN;
      pass_d     = '0;
      err_cnt_d  = '0;
      cov_d      = '0;
      err_d      = 1'b0;
      fail_in_d  = '0;
      fail_out_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN:   if (bus.STOP) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_DONE;
        default:  state_d = state_q;
      endcase

      // Capture only while running; a STOP on the same edge still captures.
      if (state_q == ST_RUN && bus.VALID) begin
        smp_v_d   = 1'b1;
        smp_in_d  = {bus.IN2, bus.IN1};
        smp_out_d = bus.OUT;
      end

      // Retire the registered sample; this also happens during DRAIN.
      if (smp_v_q) begin
        cov_d[smp_in_q] = 1'b1;
        if (match) begin
          if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
        end else begin
          if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
          err_d = 1'b1;
          if (!err_q) begin
            fail_in_d  = smp_in_q;
            fail_out_d = smp_out_q;
          end
        end
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State, pipeline and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      smp_v_q    <= 1'b0;
      smp_in_q   <= '0;
      smp_out_q  <= 1'b0;
      pass_q     <= '0;
      err_cnt_q  <= '0;
      cov_q      <= '0;
      err_q      <= 1'b0;
      fail_in_q  <= '0;
      fail_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      smp_v_q    <= smp_v_d;
      smp_in_q   <= smp_in_d;
      smp_out_q  <= smp_out_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      cov_q      <= cov_d;
      err_q      <= err_d;
      fail_in_q  <= fail_in_d;
      fail_out_q <= fail_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.PASS_CNT  = pass_q;
  assign bus.ERR_CNT   = err_cnt_q;
  assign bus.COV       = cov_q;
  assign bus.ERR       = err_q;
  assign bus.FAIL_IN   = fail_in_q;
  assign bus.FAIL_OUT  = fail_out_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.RESULT_OK = done_q & ~err_q & (cov_q == 4'hF);

endmodule

// File: tb/tb_gate2_checker.sv
// Self-checking bench for gate2_checker: a table of AND-gate runs (clean and
// with injected faults) plus directed sequences for X handling, pipeline
// edges, restart, asynchronous reset and counter saturation.
module tb_gate2_checker;

  logic clk;
  logic rst_n;

  gate2_checker_if #(.CNT_W(16)) bus ();
  gate2_checker_if #(.CNT_W(2))  sbus ();

  gate2_checker #(.CNT_W(16), .FUNC(0)) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  gate2_checker #(.CNT_W(2), .FUNC(1)) u_sat (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (sbus)
  );

  typedef struct {
    logic       restart;  // pulse START before this row
    logic       in1;
    logic       in2;
    logic       out;
    int         pass;     // expected PASS_CNT once the row has retired
    int         errs;     // expected ERR_CNT
    logic [3:0] cov;
    logic       err;
    logic [1:0] fail_in;
    logic       fail_out;
    logic       ok;       // expected RESULT_OK if the run stopped after this row
  } vec_t;

  vec_t vec [8];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  // One sample: captured on the first edge, retired on the second.
  task automatic apply(input logic a, input logic b, input logic o);
    bus.IN1   = a;
    bus.IN2   = b;
    bus.OUT   = o;
    bus.VALID = 1'b1;
    tick();
    bus.VALID = 1'b0;
    tick();
  endtask

  task automatic stop_run(input string tag);
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
    check({tag, " drain busy"}, 32'(bus.BUSY), 32'd1);
    check({tag, " drain done"}, 32'(bus.DONE), 32'd0);
    tick();
    check({tag, " done"}, 32'(bus.DONE), 32'd1);
    check({tag, " busy off"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " pass"}, 32'(bus.PASS_CNT), 32'd0);
    check({tag, " errcnt"}, 32'(bus.ERR_CNT), 32'd0);
    check({tag, " cov"}, 32'(bus.COV), 32'd0);
    check({tag, " err"}, 32'(bus.ERR), 32'd0);
    check({tag, " fail_in"}, 32'(bus.FAIL_IN), 32'd0);
    check({tag, " fail_out"}, 32'(bus.FAIL_OUT), 32'd0);
  endtask

  task automatic apply_s(input logic a, input logic b, input logic o);
    sbus.IN1   = a;
    sbus.IN2   = b;
    sbus.OUT   = o;
    sbus.VALID = 1'b1;
    tick();
    sbus.VALID = 1'b0;
    tick();
  endtask

  initial begin
    bus.START  = 1'b0; bus.STOP  = 1'b0; bus.VALID  = 1'b0;
    bus.IN1    = 1'b0; bus.IN2   = 1'b0; bus.OUT    = 1'b0;
    sbus.START = 1'b0; sbus.STOP = 1'b0; sbus.VALID = 1'b0;
    sbus.IN1   = 1'b0; sbus.IN2  = 1'b0; sbus.OUT   = 1'b0;

    //           rst  in1   in2   out  pass err cov      err   fin    fout  ok
    vec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0};
    vec[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 4'b0011, 1'b0, 2'b00, 1'b0, 1'b0};
    vec[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 0, 4'b0111, 1'b0, 2'b00, 1'b0, 1'b0};
    vec[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 4, 0, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b1};
    vec[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0};
    vec[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 4'b0011, 1'b1, 2'b01, 1'b1, 1'b0};
    vec[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 4'b0111, 1'b1, 2'b01, 1'b1, 1'b0};
    vec[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 2, 4'b1111, 1'b1, 2'b01, 1'b1, 1'b0};

    // Reset applied between edges, checked before any clock edge.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_cleared("reset");
    check("reset busy", 32'(bus.BUSY), 32'd0);
    check("reset done", 32'(bus.DONE), 32'd0);
    check("reset ok", 32'(bus.RESULT_OK), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // IDLE ignores VALID.
    apply(1'b1, 1'b1, 1'b0);
    check("idle ignores valid", 32'(bus.ERR_CNT), 32'd0);
    check("idle not busy", 32'(bus.BUSY), 32'd0);

    // Table: clean AND run, then a faulty run started from DONE.
    for (int i = 0; i < 8; i++) begin
      if (vec[i].restart) begin
        if (i > 0) begin
          stop_run($sformatf("row%0d prev", i));
          check($sformatf("row%0d prev result_ok", i), 32'(bus.RESULT_OK), 32'(vec[i-1].ok));
        end
        pulse_start();
        check_cleared($sformatf("row%0d start", i));
        check($sformatf("row%0d start busy", i), 32'(bus.BUSY), 32'd1);
      end
      apply(vec[i].in1, vec[i].in2, vec[i].out);
      check($sformatf("row%0d pass", i), 32'(bus.PASS_CNT), 32'(vec[i].pass));
      check($sformatf("row%0d errcnt", i), 32'(bus.ERR_CNT), 32'(vec[i].errs));
      check($sformatf("row%0d cov", i), 32'(bus.COV), 32'(vec[i].cov));
      check($sformatf("row%0d err", i), 32'(bus.ERR), 32'(vec[i].err));
      check($sformatf("row%0d fail_in", i), 32'(bus.FAIL_IN), 32'(vec[i].fail_in));
      check($sformatf("row%0d fail_out", i), 32'(bus.FAIL_OUT), 32'(vec[i].fail_out));
    end
    stop_run("table end");
    check("table end result_ok", 32'(bus.RESULT_OK), 32'(vec[7].ok));

    // Incomplete coverage with an unknown OUT on input 11.
    pulse_start();
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'bx);
    stop_run("xcov");
    check("xcov cov", 32'(bus.COV), 32'h9);
    check("xcov errcnt", 32'(bus.ERR_CNT), 32'd1);
    check("xcov pass", 32'(bus.PASS_CNT), 32'd1);
    check("xcov result_ok", 32'(bus.RESULT_OK), 32'd0);

    // Back-to-back VALID, STOP together with the third sample.
    pulse_start();
    bus.VALID = 1'b1;
    bus.IN1 = 1'b0; bus.IN2 = 1'b0; bus.OUT = 1'b0;
    tick();
    bus.IN1 = 1'b1; bus.IN2 = 1'b0; bus.OUT = 1'b0;
    tick();
    check("b2b first retired", 32'(bus.PASS_CNT), 32'd1);
    bus.IN1 = 1'b1; bus.IN2 = 1'b1; bus.OUT = 1'b1;
    bus.STOP = 1'b1;
    tick();
    bus.VALID = 1'b0;
    bus.STOP  = 1'b0;
    check("b2b drain pass", 32'(bus.PASS_CNT), 32'd2);
    check("b2b drain busy", 32'(bus.BUSY), 32'd1);
    check("b2b drain done", 32'(bus.DONE), 32'd0);
    tick();
    check("b2b pass", 32'(bus.PASS_CNT), 32'd3);
    check("b2b done", 32'(bus.DONE), 32'd1);
    check("b2b busy off", 32'(bus.BUSY), 32'd0);

    // START and STOP together: START wins, state stays RUN.
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    check("ss busy", 32'(bus.BUSY), 32'd1);
    check("ss done", 32'(bus.DONE), 32'd0);
    check("ss pass", 32'(bus.PASS_CNT), 32'd0);
    tick();
    tick();
    check("ss still run", 32'(bus.DONE), 32'd0);
    check("ss still busy", 32'(bus.BUSY), 32'd1);

    // A restart drops a sample that is still in the pipeline.
    bus.IN1 = 1'b1; bus.IN2 = 1'b0; bus.OUT = 1'b1;
    bus.VALID = 1'b1;
    tick();
    bus.VALID = 1'b0;
    pulse_start();
    check_cleared("drop pending");

    // Asynchronous reset mid-run after two errors.
    apply(1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b0);
    check("pre-reset errcnt", 32'(bus.ERR_CNT), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_cleared("midreset");
    check("midreset busy", 32'(bus.BUSY), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check("post-reset idle", 32'(bus.BUSY), 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) apply(vec[i].in1, vec[i].in2, vec[i].out);
    stop_run("after reset");
    check("after reset result_ok", 32'(bus.RESULT_OK), 32'd1);
    check("after reset pass", 32'(bus.PASS_CNT), 32'd4);

    // Saturation on the 2-bit OR-gate checker.
    sbus.START = 1'b1;
    tick();
    sbus.START = 1'b0;
    apply_s(1'b0, 1'b0, 1'b0);
    apply_s(1'b1, 1'b0, 1'b1);
    apply_s(1'b0, 1'b1, 1'b1);
    check("sat pass at 3", 32'(sbus.PASS_CNT), 32'd3);
    apply_s(1'b1, 1'b1, 1'b1);
    apply_s(1'b1, 1'b1, 1'b1);
    check("sat pass held", 32'(sbus.PASS_CNT), 32'd3);
    check("sat errcnt", 32'(sbus.ERR_CNT), 32'd0);
    sbus.STOP = 1'b1;
    tick();
    sbus.STOP = 1'b0;
    tick();
    check("sat done", 32'(sbus.DONE), 32'd1);
    check("sat result_ok", 32'(sbus.RESULT_OK), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
